// File: rtl/bomb_ctrl.sv
// bomb_ctrl: places one bomb at a time into the tile map, runs its fuse,
// then resolves the blast in four directions through the map ports.
module bomb_ctrl #(
    parameter int NUM_ROW     = 11,
    parameter int NUM_COL     = 19,
    parameter int DATA_WIDTH  = 2,
    parameter int FUSE_CYCLES = 200_000_000,
    parameter int BLAST_RANGE = 2,
    localparam int ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  map_ready,
    input  logic                  place_req,
    input  logic [ADDR_WIDTH-1:0] place_addr,
    output logic                  place_ack,
    output logic                  place_rej,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  blast_valid,
    output logic [ADDR_WIDTH-1:0] blast_addr,
    output logic                  done
);

    localparam int NUM_TILES = NUM_ROW * NUM_COL;
    localparam int FW = (FUSE_CYCLES > 1) ? $clog2(FUSE_CYCLES) : 1;
    localparam int KW = $clog2(BLAST_RANGE + 1);

    localparam logic [DATA_WIDTH-1:0] T_NONE  = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] T_DESTR = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] T_BOMB  = DATA_WIDTH'(3);

    localparam logic [FW-1:0] FUSE_LAST = FW'(FUSE_CYCLES - 1);
    localparam logic [KW-1:0] K_MAX     = KW'(BLAST_RANGE);
    localparam logic [KW-1:0] K_ONE     = KW'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK_WAIT,
        S_CHK_EVAL,
        S_FUSE,
        S_CENTER,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_target;
    logic [ADDR_WIDTH-1:0] r_row;
    logic [ADDR_WIDTH-1:0] r_col;
    logic [FW-1:0]         r_fuse;
    logic [1:0]            r_dir;
    logic [KW-1:0]         r_k;
    logic                  r_place_ack;
    logic                  r_place_rej;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_blast_valid;
    logic [ADDR_WIDTH-1:0] r_blast_addr;
    logic                  r_done;

    state_t                w_state;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_row;
    logic [ADDR_WIDTH-1:0] w_col;
    logic [FW-1:0]         w_fuse;
    logic [1:0]            w_dir;
    logic [KW-1:0]         w_k;
    logic                  w_place_ack;
    logic                  w_place_rej;
    logic                  w_busy;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_blast_valid;
    logic [ADDR_WIDTH-1:0] w_blast_addr;
    logic                  w_done;
    logic                  w_end;

    logic                  w_hit;
    logic [1:0]            w_hit_dir;
    logic [KW-1:0]         w_hit_k;
    logic [ADDR_WIDTH-1:0] w_hit_addr;

    // First in-grid step from the current direction onward; later directions start at k=1
    always_comb begin
        int v_k;
        int v_r;
        int v_c;
        v_k        = 0;
        v_r        = 0;
        v_c        = 0;
        w_hit      = 1'b0;
        w_hit_dir  = r_dir;
        w_hit_k    = r_k;
        w_hit_addr = '0;
        for (int d = 0; d < 4; d++) begin
            if (!w_hit && d >= int'(r_dir)) begin
                v_k = (d == int'(r_dir)) ? int'(r_k) : 1;
                v_r = int'(r_row);
                v_c = int'(r_col);
                case (d)
                    0:       v_r = v_r - v_k;
                    1:       v_r = v_r + v_k;
                    2:       v_c = v_c - v_k;
                    default: v_c = v_c + v_k;
                endcase
                if (v_r >= 0 && v_r < NUM_ROW && v_c >= 0 && v_c < NUM_COL) begin
                    w_hit      = 1'b1;
                    w_hit_dir  = 2'(d);
                    w_hit_k    = KW'(v_k);
                    w_hit_addr = ADDR_WIDTH'(v_r * NUM_COL + v_c);
                end
            end
        end
    end

    // Next-state and next-output decisions; every output is registered below
    always_comb begin
        w_state       = r_state;
        w_target      = r_target;
        w_row         = r_row;
        w_col         = r_col;
        w_fuse        = r_fuse;
        w_dir         = r_dir;
        w_k           = r_k;
        w_place_ack   = 1'b0;
        w_place_rej   = 1'b0;
        w_busy        = r_busy;
        w_rd_addr     = r_rd_addr;
        w_we          = 1'b0;
        w_wr_addr     = r_wr_addr;
        w_wr_data     = r_wr_data;
        w_blast_valid = 1'b0;
        w_blast_addr  = r_blast_addr;
        w_done        = 1'b0;
        w_end         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (place_req && map_ready) begin
                    if (int'(place_addr) >= NUM_TILES) begin
                        w_place_rej = 1'b1;
                    end else begin
                        w_target  = place_addr;
                        w_row     = ADDR_WIDTH'(int'(place_addr) / NUM_COL);
                        w_col     = ADDR_WIDTH'(int'(place_addr) % NUM_COL);
                        w_busy    = 1'b1;
                        w_rd_addr = place_addr;
                        w_state   = S_CHK_WAIT;
                    end
                end
            end
            S_CHK_WAIT: w_state = S_CHK_EVAL;
            S_CHK_EVAL: begin
                if (rd_data == T_NONE) begin
                    w_we        = 1'b1;
                    w_wr_addr   = r_target;
                    w_wr_data   = T_BOMB;
                    w_place_ack = 1'b1;
                    w_fuse      = '0;
                    w_state     = S_FUSE;
                end else begin
                    w_place_rej = 1'b1;
                    w_busy      = 1'b0;
                    w_state     = S_IDLE;
                end
            end
            S_FUSE: begin
                if (r_fuse == FUSE_LAST) begin
                    w_state = S_CENTER;
                end else begin
                    w_fuse = r_fuse + FW'(1);
                end
            end
            S_CENTER: begin
                w_we          = 1'b1;
                w_wr_addr     = r_target;
                w_wr_data     = T_NONE;
                w_blast_valid = 1'b1;
                w_blast_addr  = r_target;
                w_dir         = 2'd0;
                w_k           = K_ONE;
                w_state       = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_hit) begin
                    w_rd_addr = w_hit_addr;
                    w_dir     = w_hit_dir;
                    w_k       = w_hit_k;
                    w_state   = S_WAIT;
                end else begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            S_WAIT: w_state = S_EVAL;
            S_EVAL: begin
                w_end = 1'b1;
                unique case (1'b1)
                    (rd_data == T_NONE): begin
                        w_blast_valid = 1'b1;
                        w_blast_addr  = r_rd_addr;
                        if (r_k < K_MAX) begin
                            w_end   = 1'b0;
                            w_k     = r_k + K_ONE;
                            w_state = S_ISSUE;
                        end
                    end
                    (rd_data == T_DESTR): begin
                        w_we          = 1'b1;
                        w_wr_addr     = r_rd_addr;
                        w_wr_data     = T_NONE;
                        w_blast_valid = 1'b1;
                        w_blast_addr  = r_rd_addr;
                    end
                    default: ;
                endcase
                if (w_end) begin
                    if (r_dir == 2'd3) begin
                        w_state = S_DONE;
                    end else begin
                        w_dir   = r_dir + 2'd1;
                        w_k     = K_ONE;
                        w_state = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State, bookkeeping and output registers; reset abandons any operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_target      <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_fuse        <= '0;
            r_dir         <= '0;
            r_k           <= '0;
            r_place_ack   <= 1'b0;
            r_place_rej   <= 1'b0;
            r_busy        <= 1'b0;
            r_rd_addr     <= '0;
            r_we          <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_blast_valid <= 1'b0;
            r_blast_addr  <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_target      <= w_target;
            r_row         <= w_row;
            r_col         <= w_col;
            r_fuse        <= w_fuse;
            r_dir         <= w_dir;
            r_k           <= w_k;
            r_place_ack   <= w_place_ack;
            r_place_rej   <= w_place_rej;
            r_busy        <= w_busy;
            r_rd_addr     <= w_rd_addr;
            r_we          <= w_we;
            r_wr_addr     <= w_wr_addr;
            r_wr_data     <= w_wr_data;
            r_blast_valid <= w_blast_valid;
            r_blast_addr  <= w_blast_addr;
            r_done        <= w_done;
        end
    end

    assign place_ack   = r_place_ack;
    assign place_rej   = r_place_rej;
    assign busy        = r_busy;
    assign rd_addr     = r_rd_addr;
    assign we          = r_we;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign blast_valid = r_blast_valid;
    assign blast_addr  = r_blast_addr;
    assign done        = r_done;

endmodule

// File: doc/bomb_ctrl.md
Name: bomb_ctrl

Overview:
Gameplay-side writer for the tile map memory. It accepts one bomb placement request at a time and checks the target tile through the map's synchronous read port. It then writes the bomb code, runs the fuse timer, and resolves the blast in four directions, clearing destroyable blocks through the map's write port. It emits a per-tile blast pulse stream so player and score logic can detect hits.

Parameters:
NUM_ROW, 11, grid rows
NUM_COL, 19, grid columns
DATA_WIDTH, 2, tile code width (0 no_blk, 1 perm_blk, 2 destroyable_blk, 3 bomb)
FUSE_CYCLES, 200_000_000, clock cycles between placement and detonation (at least 1)
BLAST_RANGE, 2, maximum tiles reached per direction (at least 1)
ADDR_WIDTH (localparam), $clog2(NUM_ROW*NUM_COL), tile address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
map_ready  in  1  high when the map memory has finished its init copy; placement is blocked while low
place_req  in  1  level request to place a bomb
place_addr  in  ADDR_WIDTH  target tile (row*NUM_COL+col)
place_ack  out  1  1-cycle pulse: bomb accepted and written
place_rej  out  1  1-cycle pulse: request refused
busy  out  1  high from acceptance of a request through done
rd_addr  out  ADDR_WIDTH  map read address (registered)
rd_data  in  DATA_WIDTH  map read data, valid 1 cycle after rd_addr is sampled
we  out  1  map write enable, 1-cycle pulses
wr_addr  out  ADDR_WIDTH  map write address
wr_data  out  DATA_WIDTH  map write data
blast_valid  out  1  1-cycle pulse per blasted tile
blast_addr  out  ADDR_WIDTH  blasted tile address
done  out  1  1-cycle pulse when blast resolution completes

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; fuse counter, row/col and direction registers cleared. Reset mid-operation abandons the operation. No further writes are issued; map contents are not repaired.
- IDLE: on place_req=1 and map_ready=1, latch place_addr, set busy, go to CHK.
  - place_req is ignored when map_ready=0 or busy=1 (no ack, no rej).
  - place_addr >= NUM_ROW*NUM_COL is rejected: place_rej pulses the next cycle, no read is issued.
- CHK: drive rd_addr=target, then wait one cycle for rd_data.
  - rd_data==0: in the same cycle pulse we with wr_addr=target, wr_data=3, and pulse place_ack. Go to FUSE.
  - Otherwise: pulse place_rej, clear busy, return to IDLE.
  - place_ack or place_rej occurs exactly 2 cycles after the accepting edge.
- FUSE: the counter counts FUSE_CYCLES cycles, then go to CENTER.
- CENTER: one cycle with we=1, wr_addr=target, wr_data=0, and blast_valid=1, blast_addr=target.
- SCAN: directions are processed in the order up, down, left, right. Steps run k=1..BLAST_RANGE from the centre.
  - Neighbour row/col is computed with signed or range-checked arithmetic. Addresses wrap neither horizontally nor vertically.
  - A step outside the grid ends the direction with no read issued.
  - In-grid step: issue rd_addr, wait 1 cycle, evaluate rd_data.
  - 0: blast pulse for the tile, continue to the next step.
  - 2: write 0 to the tile, blast pulse in the same cycle, end the direction.
  - 1 or 3: end the direction with no pulse and no write.
  - Each in-grid step takes exactly 3 cycles (issue, wait, evaluate). Moving to the next direction takes 0 extra cycles.
- After the right direction ends: pulse done, clear busy, return to IDLE. A request is accepted again on the cycle after done.
- we is high for at most 1 cycle at a time. Only one write occurs per cycle. wr_addr and wr_data are valid only while we=1.
- Outputs are registered. rd_addr holds its last value when unused.

Test Plan:
- Reset: hold rst=0 while toggling place_req -> all outputs 0, busy=0. Release -> no spurious we.
- Accept: bench map all 0 except a perm border, FUSE_CYCLES=10, BLAST_RANGE=2; place_req at 20 -> rd_addr=20, and 2 cycles later we=1, wr_addr=20, wr_data=3, place_ack=1, busy=1.
- Reject: tile 45 holds 2; place_req at 45 -> place_rej 2 cycles later, no we, busy returns to 0. place_addr=209 -> place_rej, no read issued.
- Blast: centre 60; tiles 41=0, 22=2, 79=1, 59=2, 61=0, 62=0.
  - Required writes in order: 60<-3, then 60<-0, 22<-0, 59<-0.
  - Required blast_addr sequence: 60, 41, 22, 59, 61, 62, then done. 79 is never written.
- Edge: place at 0 with tiles 1, 2, 19, 38 all 0 -> no reads issued for up or left. Blast sequence: 0, 19, 38, 1, 2.
- Interference: place_req held during FUSE is ignored. map_ready=0 in IDLE blocks acceptance. rst=0 during FUSE drives outputs to 0 at once; after release, a place at 20 is accepted normally.
